// File: rtl/fc_tx_framer_if.sv
// Interface bundling the frame input, link control and transmit stream
// signals of fc_tx_framer. The framer uses the slave modport; the
// upstream/transceiver side (or a bench) uses the master modport.
interface fc_tx_framer_if;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        in_sop;
   logic        in_eop;
   logic        in_sof_sel;
   logic        in_eof_sel;
   logic [2:0]  link_state;
   logic        rrdy_req;
   logic [35:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        underrun;

   modport master (
      output in_data, in_valid, in_sop, in_eop, in_sof_sel, in_eof_sel,
      output link_state, rrdy_req, out_ready,
      input  in_ready, out_data, out_valid, underrun
   );

   modport slave (
      input  in_data, in_valid, in_sop, in_eop, in_sof_sel, in_eof_sel,
      input  link_state, rrdy_req, out_ready,
      output in_ready, out_data, out_valid, underrun
   );
endinterface

// File: rtl/fc_tx_framer.sv
// Fibre Channel 8G transmit framer: wraps upstream frames in SOF/EOF
// delimiters, fills gaps with IDLE/R_RDY honouring a minimum fill count,
// and replaces the stream with link primitives on override.
// Optional statistics counters are enabled by defining FC_TX_STATS_EN.
module fc_tx_framer #(
   parameter int unsigned MIN_FILL   = 6,
   parameter int unsigned MAX_WORDS  = 535,
   parameter int unsigned RRDY_CNT_W = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   fc_tx_framer_if.slave bus
`ifdef FC_TX_STATS_EN
   ,
   output logic [31:0]   stat_frames,
   output logic [31:0]   stat_aborts,
   output logic [31:0]   stat_rrdy
`endif
);

   localparam int unsigned FILL_W = $clog2(MIN_FILL + 1);
   localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);
   localparam logic [FILL_W-1:0] MIN_FILL_C = FILL_W'(MIN_FILL);
   localparam logic [WCNT_W-1:0] MAX_WORDS_C = WCNT_W'(MAX_WORDS);

   localparam logic [35:0] W_IDLE  = {4'b1000, 32'hBC95_B5B5};
   localparam logic [35:0] W_RRDY  = {4'b1000, 32'hBC95_4A4A};
   localparam logic [35:0] W_NOS   = {4'b1000, 32'hBC55_BF45};
   localparam logic [35:0] W_OLS   = {4'b1000, 32'hBC35_8A55};
   localparam logic [35:0] W_LR    = {4'b1000, 32'hBC49_BF49};
   localparam logic [35:0] W_LRR   = {4'b1000, 32'hBC35_DF49};
   localparam logic [35:0] W_SOFI3 = {4'b1000, 32'hBCB5_5656};
   localparam logic [35:0] W_SOFN3 = {4'b1000, 32'hBCB5_3636};
   localparam logic [35:0] W_EOFN  = {4'b1000, 32'hBC95_D5D5};
   localparam logic [35:0] W_EOFT  = {4'b1000, 32'hBC95_7575};
   localparam logic [35:0] W_EOFA  = {4'b1000, 32'hBC95_F5F5};

   typedef enum logic [2:0] {
      ST_LINK    = 3'd0,
      ST_FILL    = 3'd1,
      ST_SOF     = 3'd2,
      ST_DATA    = 3'd3,
      ST_EOF     = 3'd4,
      ST_DISCARD = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [FILL_W-1:0]     fill_q, fill_d, fill_inc_s;
   logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
   logic [RRDY_CNT_W-1:0] rrdy_q, rrdy_d;
   logic                  eof_sel_q, eof_sel_d;
   logic [35:0]           out_data_q, word_d;
   logic                  out_valid_q;
   logic                  underrun_q, underrun_d;
   logic                  in_ready_s;
   logic                  ovr_s;
   logic                  emit_rrdy_s;
   logic [35:0]           link_word_s;

   // out_ready low is handled exactly like a NOS request
   assign ovr_s      = (bus.link_state != 3'd0) || !bus.out_ready;
   assign fill_inc_s = (fill_q == MIN_FILL_C) ? fill_q : fill_q + 1'b1;

   assign bus.in_ready  = in_ready_s;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.underrun  = underrun_q;

   // Link primitive selected by link_state (NOS when transceiver not ready)
   always_comb begin
      link_word_s = W_NOS;
      if (!bus.out_ready) begin
         link_word_s = W_NOS;
      end else begin
         case (bus.link_state)
            3'd2:    link_word_s = W_OLS;
            3'd3:    link_word_s = W_LR;
            3'd4:    link_word_s = W_LRR;
            default: link_word_s = W_NOS;
         endcase
      end
   end

   // Framer FSM: next state, word selection, handshake and abort pulse
   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      wcnt_d      = wcnt_q;
      eof_sel_d   = eof_sel_q;
      word_d      = W_IDLE;
      underrun_d  = 1'b0;
      in_ready_s  = 1'b0;
      emit_rrdy_s = 1'b0;
      case (state_q)
         ST_LINK: begin
            word_d = link_word_s;
            fill_d = '0;
            if (ovr_s) begin
               state_d = ST_LINK;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (ovr_s) begin
               word_d  = link_word_s;
               fill_d  = '0;
               state_d = ST_LINK;
            end else begin
               if (rrdy_q != '0) begin
                  word_d      = W_RRDY;
                  emit_rrdy_s = 1'b1;
               end else begin
                  word_d = W_IDLE;
               end
               fill_d = fill_inc_s;
               if (bus.in_valid && bus.in_sop && (fill_inc_s == MIN_FILL_C)) begin
                  state_d = ST_SOF;
               end else if (bus.in_valid && !bus.in_sop) begin
                  // stray mid-packet word outside a frame: drop it
                  in_ready_s = 1'b1;
                  underrun_d = 1'b1;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end
         ST_SOF: begin
            if (ovr_s) begin
               word_d     = W_EOFA;
               underrun_d = 1'b1;
               fill_d     = '0;
               state_d    = ST_DISCARD;
            end else begin
               word_d  = bus.in_sof_sel ? W_SOFN3 : W_SOFI3;
               wcnt_d  = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (ovr_s) begin
               word_d     = W_EOFA;
               underrun_d = 1'b1;
               fill_d     = '0;
               state_d    = ST_DISCARD;
            end else begin
               in_ready_s = 1'b1;
               if (wcnt_q == MAX_WORDS_C) begin
                  // overlength: the word offered now is swallowed by the abort
                  word_d     = W_EOFA;
                  underrun_d = 1'b1;
                  fill_d     = '0;
                  if (bus.in_valid && bus.in_eop) begin
                     state_d = ST_FILL;
                  end else begin
                     state_d = ST_DISCARD;
                  end
               end else if (bus.in_valid) begin
                  word_d = {4'b0000, bus.in_data};
                  wcnt_d = wcnt_q + 1'b1;
                  if (bus.in_eop) begin
                     eof_sel_d = bus.in_eof_sel;
                     state_d   = ST_EOF;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  word_d     = W_EOFA;
                  underrun_d = 1'b1;
                  fill_d     = '0;
                  state_d    = ST_DISCARD;
               end
            end
         end
         ST_EOF: begin
            if (ovr_s) begin
               word_d     = W_EOFA;
               underrun_d = 1'b1;
               fill_d     = '0;
               state_d    = ST_LINK;
            end else begin
               word_d  = eof_sel_q ? W_EOFT : W_EOFN;
               fill_d  = '0;
               state_d = ST_FILL;
            end
         end
         ST_DISCARD: begin
            in_ready_s = 1'b1;
            if (ovr_s) begin
               word_d = link_word_s;
               fill_d = '0;
            end else begin
               word_d = W_IDLE;
               fill_d = fill_inc_s;
            end
            if (bus.in_valid && bus.in_eop) begin
               state_d = ovr_s ? ST_LINK : ST_FILL;
            end else begin
               state_d = ST_DISCARD;
            end
         end
         default: begin
            word_d  = W_NOS;
            fill_d  = '0;
            state_d = ST_LINK;
         end
      endcase
   end

   // Pending R_RDY count: saturating, request and emission together cancel
   always_comb begin
      rrdy_d = rrdy_q;
      if (bus.rrdy_req && emit_rrdy_s) begin
         rrdy_d = rrdy_q;
      end else if (bus.rrdy_req && (rrdy_q != {RRDY_CNT_W{1'b1}})) begin
         rrdy_d = rrdy_q + 1'b1;
      end else if (emit_rrdy_s) begin
         rrdy_d = rrdy_q - 1'b1;
      end else begin
         rrdy_d = rrdy_q;
      end
   end

   // State, counters and registered output stream
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_LINK;
         fill_q      <= '0;
         wcnt_q      <= '0;
         rrdy_q      <= '0;
         eof_sel_q   <= 1'b0;
         out_data_q  <= W_NOS;
         out_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         wcnt_q      <= wcnt_d;
         rrdy_q      <= rrdy_d;
         eof_sel_q   <= eof_sel_d;
         out_data_q  <= word_d;
         out_valid_q <= 1'b1;
         underrun_q  <= underrun_d;
      end
   end

`ifdef FC_TX_STATS_EN
   // Wrapping counters of emitted frame ends, aborts and R_RDYs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_frames <= 32'd0;
         stat_aborts <= 32'd0;
         stat_rrdy   <= 32'd0;
      end else begin
         if ((word_d == W_EOFN) || (word_d == W_EOFT)) begin
            stat_frames <= stat_frames + 32'd1;
         end
         if (word_d == W_EOFA) begin
            stat_aborts <= stat_aborts + 32'd1;
         end
         if (emit_rrdy_s) begin
            stat_rrdy <= stat_rrdy + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fc_tx_framer.sv
// Directed bench for fc_tx_framer: stimulus pushes the hand-derived word
// expected for each clock into a scoreboard queue; a monitor pops and
// compares {underrun, out_data} on every valid output cycle.
module tb_fc_tx_framer;

   localparam logic [35:0] IDLE  = 36'h8BC95B5B5;
   localparam logic [35:0] RRDY  = 36'h8BC954A4A;
   localparam logic [35:0] NOS   = 36'h8BC55BF45;
   localparam logic [35:0] LR    = 36'h8BC49BF49;
   localparam logic [35:0] SOFI3 = 36'h8BCB55656;
   localparam logic [35:0] SOFN3 = 36'h8BCB53636;
   localparam logic [35:0] EOFN  = 36'h8BC95D5D5;
   localparam logic [35:0] EOFT  = 36'h8BC957575;
   localparam logic [35:0] EOFA  = 36'h8BC95F5F5;

   logic clk;
   logic reset_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [36:0] exp_q[$];

   fc_tx_framer_if bus_if ();

`ifdef FC_TX_STATS_EN
   logic [31:0] stat_frames;
   logic [31:0] stat_aborts;
   logic [31:0] stat_rrdy;
`endif

   fc_tx_framer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
`ifdef FC_TX_STATS_EN
      ,
      .stat_frames (stat_frames),
      .stat_aborts (stat_aborts),
      .stat_rrdy   (stat_rrdy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // expected word chosen at the coming edge, then advance one cycle
   task automatic step(input logic [35:0] w, input logic ur);
      exp_q.push_back({ur, w});
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] d, input logic sop, input logic eop);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = d;
      bus_if.in_sop   = sop;
      bus_if.in_eop   = eop;
   endtask

   task automatic idle_in();
      bus_if.in_valid = 1'b0;
      bus_if.in_sop   = 1'b0;
      bus_if.in_eop   = 1'b0;
   endtask

   // Monitor: compare every valid output word against the scoreboard
   always @(negedge clk) begin
      if (reset_n && bus_if.out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", {bus_if.underrun, bus_if.out_data}, 37'h1FFFFFFFFF);
         end else begin
            check("stream", {bus_if.underrun, bus_if.out_data}, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset_n            = 1'b0;
      bus_if.in_data     = 32'h0;
      bus_if.in_valid    = 1'b0;
      bus_if.in_sop      = 1'b0;
      bus_if.in_eop      = 1'b0;
      bus_if.in_sof_sel  = 1'b0;
      bus_if.in_eof_sel  = 1'b0;
      bus_if.link_state  = 3'd0;
      bus_if.rrdy_req    = 1'b0;
      bus_if.out_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {36'h0, bus_if.out_valid}, 37'h0);
      check("rst_out_data",  {1'b0, bus_if.out_data}, {1'b0, NOS});
      check("rst_in_ready",  {36'h0, bus_if.in_ready}, 37'h0);
      check("rst_underrun",  {36'h0, bus_if.underrun}, 37'h0);
      reset_n = 1'b1;

      // Packet A offered at once: NOS, 6 IDLE, SOFi3, 3 words, EOFt
      bus_if.in_sof_sel = 1'b0;
      offer(32'hA000_0001, 1'b1, 1'b0);
      step(NOS, 1'b0);
      for (int i = 0; i < 6; i++) step(IDLE, 1'b0);
      step(SOFI3, 1'b0);
      bus_if.rrdy_req = 1'b1;
      step({4'h0, 32'hA000_0001}, 1'b0);
      bus_if.rrdy_req = 1'b0;
      offer(32'hA000_0002, 1'b0, 1'b0);
      step({4'h0, 32'hA000_0002}, 1'b0);
      offer(32'hA000_0003, 1'b0, 1'b1);
      bus_if.in_eof_sel = 1'b1;
      bus_if.rrdy_req   = 1'b1;
      step({4'h0, 32'hA000_0003}, 1'b0);
      // back-to-back packet B waits behind the minimum fill
      bus_if.in_sof_sel = 1'b1;
      offer(32'hB000_0001, 1'b1, 1'b0);
      step(EOFT, 1'b0);
      bus_if.rrdy_req = 1'b0;
      for (int i = 0; i < 3; i++) step(RRDY, 1'b0);
      for (int i = 0; i < 3; i++) step(IDLE, 1'b0);
      step(SOFN3, 1'b0);
      step({4'h0, 32'hB000_0001}, 1'b0);
      offer(32'hB000_0002, 1'b0, 1'b1);
      bus_if.in_eof_sel = 1'b0;
      step({4'h0, 32'hB000_0002}, 1'b0);

      // Packet C: in_valid drops after word 2 of 4
      bus_if.in_sof_sel = 1'b0;
      offer(32'hC000_0001, 1'b1, 1'b0);
      step(EOFN, 1'b0);
      for (int i = 0; i < 6; i++) step(IDLE, 1'b0);
      step(SOFI3, 1'b0);
      step({4'h0, 32'hC000_0001}, 1'b0);
      offer(32'hC000_0002, 1'b0, 1'b0);
      step({4'h0, 32'hC000_0002}, 1'b0);
      idle_in();
      step(EOFA, 1'b1);
      step(IDLE, 1'b0);
      offer(32'hC000_0003, 1'b0, 1'b0);
      step(IDLE, 1'b0);
      offer(32'hC000_0004, 1'b0, 1'b1);
      step(IDLE, 1'b0);
      idle_in();
      for (int i = 0; i < 3; i++) step(IDLE, 1'b0);

      // Packet D: link_state=3 mid-frame, remainder drained under LR
      offer(32'hD000_0001, 1'b1, 1'b0);
      step(IDLE, 1'b0);
      step(SOFI3, 1'b0);
      step({4'h0, 32'hD000_0001}, 1'b0);
      offer(32'hD000_0002, 1'b0, 1'b0);
      step({4'h0, 32'hD000_0002}, 1'b0);
      offer(32'hD000_0003, 1'b0, 1'b0);
      bus_if.link_state = 3'd3;
      step(EOFA, 1'b1);
      step(LR, 1'b0);
      offer(32'hD000_0004, 1'b0, 1'b1);
      step(LR, 1'b0);
      idle_in();
      bus_if.out_ready = 1'b0;
      step(NOS, 1'b0);
      bus_if.out_ready = 1'b1;
      step(LR, 1'b0);
      step(LR, 1'b0);
      bus_if.link_state = 3'd0;
      bus_if.in_eof_sel = 1'b0;
      offer(32'hE000_0001, 1'b1, 1'b1);
      step(NOS, 1'b0);
      for (int i = 0; i < 6; i++) step(IDLE, 1'b0);
      step(SOFI3, 1'b0);
      step({4'h0, 32'hE000_0001}, 1'b0);
      idle_in();
      step(EOFN, 1'b0);

      // Packet F: MAX_WORDS+1 words, last replaced by EOFa
      offer(32'hF000_0001, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(IDLE, 1'b0);
      step(SOFI3, 1'b0);
      for (int i = 1; i <= 536; i++) begin
         logic [31:0] wd;
         wd = 32'hF000_0000 + 32'(i);
         offer(wd, (i == 1), (i == 536));
         if (i <= 535) begin
            step({4'h0, wd}, 1'b0);
         end else begin
            step(EOFA, 1'b1);
         end
      end
      idle_in();
      for (int i = 0; i < 3; i++) step(IDLE, 1'b0);

      @(negedge clk);
      #1;
      check("scoreboard_drained", 37'(exp_q.size()), 37'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
